sram2rw_fifo: RTL and testbench
===============================

# sram2rw_fifo

- Synchronous first-word-fall-through FIFO of 16-bit words, built around one SRAM2RW16x16 dual-port macro.
- It is the initiator side of the macro interface: generates chip-select, write-enable, output-enable, address and write data, and consumes macro read data.
- Port 1 of the macro is used write-only (enqueue); port 2 is used read-only (dequeue).
- Sits between a producer and a consumer using valid/ready handshakes.

## Interface

Parameters:

- WIDTH, 16, word width; fixed by the macro.
- ADDR_W, 4, macro address width; fixed by the macro.
- DEPTH, 16, macro words; total capacity is DEPTH+1 (macro plus output stage).

Ports:

- clk  in  1  single clock; also drives both macro CE pins.
- rst  in  1  reset, asynchronous, active-high.
- enq_valid  in  1  producer has a word.
- enq_ready  out  1  FIFO accepts a word this cycle.
- enq_data  in  WIDTH  word to enqueue.
- deq_valid  out  1  deq_data holds the head word.
- deq_ready  in  1  consumer takes the head word this cycle.
- deq_data  out  WIDTH  head word; don't-care while deq_valid=0.
- count  out  5  words held, 0..17: mem_count + deq_valid.

## Operation

**State registers:**

- wr_ptr[3:0]
- rd_ptr[3:0]
- mem_count[4:0] (0..16): words written to the macro but not yet read.
- deq_valid

**Reset values:** all of the above are 0, so enq_ready=1, deq_valid=0 and count=0. Macro contents are not cleared.

**Enqueue:**

- enq_ready = (mem_count != 16).
- enq_fire = enq_valid & enq_ready.
- On enq_fire, the block drives the macro with CSB1=0, WEB1=0, A1=wr_ptr, I1=enq_data. wr_ptr increments mod 16 at the edge.
- OEB1 is tied to 1.
- enq_valid while not ready is ignored; no state changes.

**Dequeue:**

- rd_issue = (mem_count != 0) & (~deq_valid | deq_ready).
- On rd_issue, the block drives CSB2=0, WEB2=1, A2=rd_ptr. rd_ptr increments mod 16 at the edge.
- OEB2 is tied to 0 and I2 is tied to 0.
- deq_data is wired directly to the macro O2. The macro holds O2 until its next port-2 read, so the head word stays stable while stalled.
- deq_valid next state: 1 if rd_issue; else 0 if deq_ready; else hold.

**Count update:** mem_count_next = mem_count + enq_fire - rd_issue. Simultaneous enqueue and read leave it unchanged.

**Same-address rule:**

- A read only targets a slot whose write completed at an earlier edge, because rd_issue uses registered mem_count.
- The macro therefore never sees a read and a write to the same address on the same edge. This invariant is mandatory.

**Boundary conditions:**

- Full: mem_count=16 forces enq_ready=0, even if a read issues the same cycle. No combinational ready-from-read path.
- Empty: mem_count=0 with deq_valid=1 and deq_ready=1 drops deq_valid to 0.
- Pointer wrap: 15 wraps to 0 silently.
- Reset mid-operation: all queued words are discarded, and deq_valid falls immediately, asynchronously.

## Timing

- Enqueue-to-dequeue latency into an empty FIFO: a word accepted at edge N is written at N. The read issues at N+1, and deq_valid=1 with valid deq_data after edge N+1 (2 cycles).
- Throughput: 1 word/cycle sustained in both directions once deq_valid=1.
- deq_valid, count and enq_ready are functions of registers only.
- Macro control pins (CSB, A, I) are combinational from registers plus enq_valid and deq_ready, and must be settled before the rising edge of clk.

## Structure

- Shared package: WIDTH=16, ADDR_W=4, DEPTH=16, COUNT_W=5.
- One sub-module: the SRAM2RW16x16 instance, named u_sram, with CE1=CE2=clk.
- Pointer, count and handshake logic stay flat in sram2rw_fifo. No further sub-modules.

## Test plan

- **Reset:** assert rst mid-stream with 5 words queued -> deq_valid=0, enq_ready=1 and count=0 immediately; the next enqueue of 0xBEEF is dequeued as 0xBEEF.
- **Single word:** enqueue 0x1234 at edge N with deq_ready=1 -> deq_valid rises after N+1 with deq_data=0x1234; count goes 1 then 0 after the pop.
- **Fill to full:** hold deq_ready=0 and push 0x0000..0x0010 (17 words) -> enq_ready=0 when count=17; an 18th push is ignored; drain yields 0x0000..0x0010 in order.
- **Stall stability:** deq_ready=0 for 10 cycles with head 0xA5A5 while enqueuing 3 more -> deq_data remains 0xA5A5 throughout.
- **Streaming with wrap:** 100 words with enq_valid and deq_ready both at 1 -> one word per cycle after 2-cycle fill, in order, count steady at 1-2, pointers wrap ≥6 times.
- **Random:** random enq_valid/deq_ready for 5000 cycles against a scoreboard queue -> no loss, duplication or reordering; count always equals the model depth.

Source files
------------

// File: rtl/sram2rw_fifo_pkg.sv
// rtl/sram2rw_fifo_pkg.sv - shared constants for the SRAM2RW16x16-backed FIFO
//
// Purpose: word/address/depth constants of the SRAM2RW16x16 macro and the
// width of the occupancy count (0..DEPTH+1 words) seen by the FIFO user.
// Ports: none (package).

package sram2rw_fifo_pkg;

  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int COUNT_W = 5;

endpackage : sram2rw_fifo_pkg

// File: rtl/SRAM2RW16x16.sv
// rtl/SRAM2RW16x16.sv - behavioural model of the 16x16 dual-port SRAM macro
//
// Purpose: synchronous dual-port SRAM, 16 words of 16 bits. Each port has
// its own clock (CEn), active-low chip select (CSBn), write enable (WEBn,
// 0 = write, 1 = read) and output enable (OEBn, 0 = drive On). A read
// registers the word into the port output latch, which then holds until the
// next read on that port. Contents are not initialised.
// Ports:
//   CE1/CE2   port clocks
//   CSB1/CSB2 chip selects, active low
//   WEB1/WEB2 write enables, active low
//   OEB1/OEB2 output enables, active low
//   A1/A2     word addresses
//   I1/I2     write data
//   O1/O2     read data
// Port 2 writes are not modelled; the FIFO only ever reads on port 2.

module SRAM2RW16x16 (
  input  logic        CE1,
  input  logic        CE2,
  input  logic        CSB1,
  input  logic        CSB2,
  input  logic        WEB1,
  input  logic        WEB2,
  input  logic        OEB1,
  input  logic        OEB2,
  input  logic [3:0]  A1,
  input  logic [3:0]  A2,
  input  logic [15:0] I1,
  input  logic [15:0] I2,
  output logic [15:0] O1,
  output logic [15:0] O2
);

  logic [15:0] mem [16];
  logic [15:0] o1_q;
  logic [15:0] o2_q;

  // Port 2 write data has no effect in this model.
  logic unused_i2;
  assign unused_i2 = ^I2;

  always_ff @(posedge CE1) begin
    if (!CSB1) begin
      if (!WEB1) begin
        mem[A1] <= I1;
      end else begin
        o1_q <= mem[A1];
      end
    end
  end

  always_ff @(posedge CE2) begin
    if (!CSB2 && WEB2) begin
      o2_q <= mem[A2];
    end
  end

  // A disabled output reads as zero rather than floating.
  assign O1 = OEB1 ? 16'h0000 : o1_q;
  assign O2 = OEB2 ? 16'h0000 : o2_q;

endmodule : SRAM2RW16x16

// File: rtl/sram2rw_fifo.sv
// rtl/sram2rw_fifo.sv - first-word-fall-through FIFO around one SRAM2RW16x16
//
// Purpose: 16-bit FWFT FIFO. Macro port 1 is write-only (enqueue), port 2 is
// read-only (dequeue). The port-2 output latch acts as the output stage, so
// capacity is DEPTH macro words plus the head word.
// Ports:
//   clk        clock, also both macro CE pins
//   rst        asynchronous active-high reset
//   enq_valid  producer has a word          enq_ready  FIFO accepts a word
//   enq_data   word to enqueue
//   deq_valid  deq_data holds the head      deq_ready  consumer takes head
//   deq_data   head word (don't-care while deq_valid=0)
//   count      words held: mem_count + deq_valid

module sram2rw_fifo
  import sram2rw_fifo_pkg::*;
#(
  parameter int WIDTH  = sram2rw_fifo_pkg::WIDTH,
  parameter int ADDR_W = sram2rw_fifo_pkg::ADDR_W,
  parameter int DEPTH  = sram2rw_fifo_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [WIDTH-1:0]   enq_data,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [WIDTH-1:0]   deq_data,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] MEM_FULL = COUNT_W'(DEPTH);

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] mem_count_q, mem_count_d;
  logic               deq_valid_q, deq_valid_d;

  logic enq_fire;
  logic rd_issue;

  // Macro pins
  logic             sram_csb1, sram_web1, sram_oeb1;
  logic             sram_csb2, sram_web2, sram_oeb2;
  logic [WIDTH-1:0] sram_i2;
  logic [WIDTH-1:0] sram_o1_unused;
  logic [WIDTH-1:0] sram_o2;

  // Ready depends on registered occupancy only: a read issuing this cycle
  // does not free a slot for a same-cycle write.
  assign enq_ready = (mem_count_q != MEM_FULL);
  assign enq_fire  = enq_valid & enq_ready;

  // A read only targets words already written at an earlier edge, which also
  // keeps port 1 and port 2 off the same address on the same edge.
  assign rd_issue  = (mem_count_q != '0) & (~deq_valid_q | deq_ready);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    deq_valid_d = deq_valid_q;

    if (enq_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({enq_fire, rd_issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase

    if (rd_issue) begin
      deq_valid_d = 1'b1;
    end else if (deq_ready) begin
      deq_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      deq_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      deq_valid_q <= deq_valid_d;
    end
  end

  assign sram_csb1 = ~enq_fire;
  assign sram_web1 = 1'b0;
  assign sram_oeb1 = 1'b1;
  assign sram_csb2 = ~rd_issue;
  assign sram_web2 = 1'b1;
  assign sram_oeb2 = 1'b0;
  assign sram_i2   = '0;

  SRAM2RW16x16 u_sram (
    .CE1  (clk),
    .CE2  (clk),
    .CSB1 (sram_csb1),
    .CSB2 (sram_csb2),
    .WEB1 (sram_web1),
    .WEB2 (sram_web2),
    .OEB1 (sram_oeb1),
    .OEB2 (sram_oeb2),
    .A1   (wr_ptr_q),
    .A2   (rd_ptr_q),
    .I1   (enq_data),
    .I2   (sram_i2),
    .O1   (sram_o1_unused),
    .O2   (sram_o2)
  );

  // The port-2 output latch holds the head word while the consumer stalls.
  assign deq_data  = sram_o2;
  assign deq_valid = deq_valid_q;
  assign count     = mem_count_q + COUNT_W'(deq_valid_q);

endmodule : sram2rw_fifo

// File: tb/tb_sram2rw_fifo.sv
// tb/tb_sram2rw_fifo.sv - scoreboard bench for sram2rw_fifo

module tb_sram2rw_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [15:0] enq_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_data;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: every accepted word, head first. Model of the macro
  // occupancy and of the output stage as the FIFO's contract defines them.
  logic [15:0] sb[$];
  int          m_mem;
  bit          m_dv;

  always #5 clk = ~clk;

  sram2rw_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count)
  );

  // Advance the model by one edge with the currently driven inputs, then
  // step the clock and land 1 time unit after the edge.
  task automatic tick();
    bit fire;
    bit issue;
    fire  = enq_valid && (m_mem != 16);
    issue = (m_mem != 0) && (!m_dv || deq_ready);
    if (fire) sb.push_back(enq_data);
    m_mem = m_mem + int'(fire) - int'(issue);
    if (issue) m_dv = 1'b1;
    else if (deq_ready) m_dv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_mem = 0;
    m_dv  = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b want=0", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b want=1", enq_ready); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    rst = 1'b0;
    // Queue five words with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_data = 16'h5000 + 16'(i);
      checks++; if (count !== 5'(sb.size())) begin failures++; $display("FAIL reset_fill_count got=%0d want=%0d", count, sb.size()); end
      tick();
    end
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL reset_pre_count got=%0d want=5", count); end
    // Asynchronous reset in the middle of a cycle.
    #3 rst = 1'b1;
    #1;
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_deq_valid got=%b want=0", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_enq_ready got=%b want=1", enq_ready); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_mid_count got=%0d want=0", count); end
    model_clear();
    enq_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    enq_valid = 1'b1; enq_data = 16'hBEEF; deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (m_dv && deq_ready) begin
        exp = sb.pop_front();
        checks++; if (deq_data !== exp) begin failures++; $display("FAIL reset_beef_data got=%h want=%h", deq_data, exp); end
      end
      tick();
    end
    checks++; if (count !== 5'd0 || sb.size() != 0) begin failures++; $display("FAIL reset_beef_drain count=%0d sb=%0d want=0", count, sb.size()); end
  endtask

  task automatic test_single_word();
    enq_valid = 1'b1; enq_data = 16'h1234; deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_n got=%0d want=1", count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n got=%b want=0", deq_valid); end
    tick();
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL single_valid_n1 got=%b want=1", deq_valid); end
    checks++; if (deq_data !== 16'h1234) begin failures++; $display("FAIL single_data got=%h want=1234", deq_data); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_n1 got=%0d want=1", count); end
    void'(sb.pop_front());
    tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count_pop got=%0d want=0", count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_pop got=%b want=0", deq_valid); end
  endtask

  task automatic test_fill_full();
    deq_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      enq_valid = 1'b1; enq_data = 16'(i);
      checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fill_ready i=%0d got=%b want=1", i, enq_ready); end
      tick();
    end
    checks++; if (count !== 5'd17) begin failures++; $display("FAIL fill_count got=%0d want=17", count); end
    checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b want=0", enq_ready); end
    enq_data = 16'h0011;
    tick();
    enq_valid = 1'b0;
    checks++; if (count !== 5'd17) begin failures++; $display("FAIL fill_extra_count got=%0d want=17", count); end
    checks++; if (sb.size() != 17 || sb[16] !== 16'h0010) begin failures++; $display("FAIL fill_model size=%0d want=17", sb.size()); end
  endtask

  task automatic test_stall();
    enq_valid = 1'b1; enq_data = 16'hA5A5; deq_ready = 1'b0;
    tick();
    enq_valid = 1'b0;
    tick();
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL stall_head_valid got=%b want=1", deq_valid); end
    for (int c = 0; c < 10; c++) begin
      enq_valid = (c < 3); enq_data = 16'hC000 + 16'(c);
      checks++; if (deq_data !== 16'hA5A5) begin failures++; $display("FAIL stall_data c=%0d got=%h want=a5a5", c, deq_data); end
      checks++; if (count !== 5'(sb.size())) begin failures++; $display("FAIL stall_count c=%0d got=%0d want=%0d", c, count, sb.size()); end
      tick();
    end
    enq_valid = 1'b0;
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL stall_final_count got=%0d want=4", count); end
  endtask

  task automatic test_stream();
    logic [15:0] exp;
    int pops;
    pops = 0;
    deq_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      enq_valid = 1'b1; enq_data = 16'h0100 + 16'(i);
      if (i >= 2) begin
        checks++; if (count < 5'd1 || count > 5'd2) begin failures++; $display("FAIL stream_count i=%0d got=%0d want=1..2", i, count); end
      end
      if (m_dv) begin
        exp = sb.pop_front();
        pops++;
        checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL stream_data i=%0d got=%b/%h want=1/%h", i, deq_valid, deq_data, exp); end
      end
      tick();
    end
    enq_valid = 1'b0;
    checks++; if (pops != 98) begin failures++; $display("FAIL stream_rate got=%0d want=98", pops); end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int c = 0; c < 5000; c++) begin
      enq_valid = 1'($urandom_range(0, 1));
      enq_data  = 16'($urandom());
      deq_ready = ($urandom_range(0, 3) != 0) ? (c % 800 < 600) : 1'b0;
      checks++; if (count !== 5'(sb.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, count, sb.size()); end
      checks++; if (enq_ready !== (m_mem != 16)) begin failures++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, enq_ready, (m_mem != 16)); end
      checks++; if (deq_valid !== m_dv) begin failures++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, deq_valid, m_dv); end
      if (m_dv && deq_ready) begin
        exp = sb.pop_front();
        checks++; if (deq_data !== exp) begin failures++; $display("FAIL rand_data c=%0d got=%h want=%h", c, deq_data, exp); end
      end
      tick();
    end
    enq_valid = 1'b0;
  endtask

  // Empty the FIFO against the scoreboard within a fixed cycle budget.
  task automatic test_drain();
    logic [15:0] exp;
    int c;
    enq_valid = 1'b0; deq_ready = 1'b1;
    c = 0;
    while ((sb.size() != 0 || m_dv) && c < 40) begin
      checks++; if (count !== 5'(sb.size())) begin failures++; $display("FAIL drain_count got=%0d want=%0d", count, sb.size()); end
      if (m_dv) begin
        exp = sb.pop_front();
        checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL drain_data got=%b/%h want=1/%h", deq_valid, deq_data, exp); end
      end
      tick();
      c++;
    end
    checks++; if (count !== 5'd0 || deq_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL drain_empty count=%0d valid=%b sb=%0d want=0/0/0", count, deq_valid, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_full();
    test_drain();
    test_stall();
    test_drain();
    test_stream();
    test_drain();
    test_random();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sram2rw_fifo
